// File: rtl/config_usb_pkg.sv
// Shared types and constants for the USB-CDC configuration packer.
package config_usb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GET_CMD  = 2'd1,
    GET_DATA = 2'd2
  } state_t;

  localparam logic [7:0]  CMD_WRITE         = 8'h81;
  localparam logic [31:0] DEFAULT_SYNC_WORD = 32'hFAB0_FAB1;

endpackage

// File: rtl/config_timeout_counter.sv
// Idle-cycle counter that saturates at TIMEOUT_CYCLES-1 and flags expiry.
module config_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  // Count idle cycles while enabled; hold at terminal count instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && (count != TERMINAL)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == TERMINAL);

endmodule

// File: rtl/config_usb_packer.sv
// Turns a USB-CDC byte stream into 32-bit configuration writes.
// A session opens on SYNC_WORD, takes one command byte, and for CMD_WRITE
// packs every following group of 4 bytes MSB-first into WriteData until the
// stream goes quiet for TIMEOUT_CYCLES cycles.
module config_usb_packer
  import config_usb_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 1_000_000,
  parameter logic [31:0] SYNC_WORD      = DEFAULT_SYNC_WORD
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [31:0] WriteData,
  output logic        WriteStrobe,
  output logic        ComActive,
  output logic [7:0]  Command,
  output logic        ReceiveLED
);

  state_t      state;
  logic [31:0] search;
  logic [31:0] shift;
  logic [31:0] wdata;
  logic [1:0]  byte_cnt;
  logic [7:0]  cmd;
  logic        strobe;
  logic        active;
  logic        led;
  logic        ready;

  logic        accept;
  logic        expired;
  logic        timeout;
  logic [31:0] search_next;
  logic [31:0] shift_next;

  assign accept      = rx_valid && ready;
  // An accepted byte always beats a timeout landing in the same cycle.
  assign timeout     = active && expired && !accept;
  assign search_next = {search[23:0], rx_data};
  assign shift_next  = {shift[23:0], rx_data};

  config_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (CLK),
    .reset  (reset),
    .clear  (accept || !active),
    .enable (active),
    .expired(expired)
  );

  // Session FSM, sync search, command latch and word assembly.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state    <= IDLE;
      search   <= '0;
      shift    <= '0;
      wdata    <= '0;
      byte_cnt <= '0;
      cmd      <= '0;
      strobe   <= 1'b0;
      active   <= 1'b0;
      led      <= 1'b0;
      ready    <= 1'b0;
    end else begin
      ready  <= 1'b1;
      strobe <= 1'b0;
      if (accept) begin
        case (state)
          IDLE: begin
            search <= search_next;
            // Match on the incoming byte so a command sent back-to-back
            // with the sync pattern is not swallowed by the search.
            if (search_next == SYNC_WORD) begin
              state  <= GET_CMD;
              active <= 1'b1;
            end
          end
          GET_CMD: begin
            cmd <= rx_data;
            if (rx_data == CMD_WRITE) begin
              state    <= GET_DATA;
              byte_cnt <= '0;
            end else begin
              state  <= IDLE;
              active <= 1'b0;
              search <= '0;
            end
          end
          GET_DATA: begin
            shift    <= shift_next;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              wdata  <= shift_next;
              strobe <= 1'b1;
              led    <= ~led;
            end
          end
          default: state <= IDLE;
        endcase
      end else if (timeout) begin
        state    <= IDLE;
        active   <= 1'b0;
        byte_cnt <= '0;
        shift    <= '0;
      end
    end
  end

  assign rx_ready    = ready;
  assign WriteData   = wdata;
  assign WriteStrobe = strobe;
  assign ComActive   = active;
  assign Command     = cmd;
  assign ReceiveLED  = led;

endmodule

// File: tb/tb_config_usb_packer.sv
// Directed bench for config_usb_packer with a per-cycle reference model.
module tb_config_usb_packer;

  localparam int          TO   = 16;
  localparam logic [31:0] SYNC = 32'hFAB0_FAB1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [31:0] WriteData;
  logic        WriteStrobe;
  logic        ComActive;
  logic [7:0]  Command;
  logic        ReceiveLED;

  always #5 clk = ~clk;

  config_usb_packer #(
    .TIMEOUT_CYCLES(TO),
    .SYNC_WORD     (SYNC)
  ) dut (
    .CLK        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .WriteData  (WriteData),
    .WriteStrobe(WriteStrobe),
    .ComActive  (ComActive),
    .Command    (Command),
    .ReceiveLED (ReceiveLED)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model state
  int          cyc = 0;
  bit          m_ready, m_active, m_strobe, m_led;
  int          m_mode;   // 0 waiting for sync, 1 waiting for command, 2 collecting data
  int          m_idle;
  logic [31:0] m_search, m_wd;
  logic [7:0]  m_cmd;
  logic [7:0]  m_q[$];

  // Strobe log captured from the DUT
  logic [31:0] s_data[$];
  int          s_cyc[$];

  initial begin : model
    bit acc;
    m_ready = 0; m_active = 0; m_strobe = 0; m_led = 0;
    m_mode = 0; m_idle = 0; m_search = '0; m_wd = '0; m_cmd = '0;
    forever begin
      @(posedge clk);
      cyc++;
      if (reset) begin
        m_ready = 0; m_active = 0; m_strobe = 0; m_led = 0;
        m_mode = 0; m_idle = 0; m_search = '0; m_wd = '0; m_cmd = '0;
        m_q.delete();
      end else begin
        acc = rx_valid && m_ready;
        m_strobe = 0;
        if (acc) begin
          m_idle = 0;
          if (m_mode == 0) begin
            m_search = {m_search[23:0], rx_data};
            if (m_search == SYNC) begin
              m_mode = 1;
              m_active = 1;
            end
          end else if (m_mode == 1) begin
            m_cmd = rx_data;
            if (rx_data == 8'h81) begin
              m_mode = 2;
              m_q.delete();
            end else begin
              m_mode = 0;
              m_active = 0;
              m_search = '0;
            end
          end else begin
            m_q.push_back(rx_data);
            if (m_q.size() == 4) begin
              m_wd = {m_q[0], m_q[1], m_q[2], m_q[3]};
              m_strobe = 1;
              m_led = ~m_led;
              m_q.delete();
            end
          end
        end else if (m_active) begin
          m_idle++;
          if (m_idle == TO) begin
            m_mode = 0;
            m_active = 0;
            m_q.delete();
            m_idle = 0;
          end
        end
        m_ready = 1;
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      chk("cmp_rx_ready", rx_ready, m_ready);
      chk("cmp_write_data", WriteData, m_wd);
      chk("cmp_write_strobe", WriteStrobe, m_strobe);
      chk("cmp_com_active", ComActive, m_active);
      chk("cmp_command", Command, m_cmd);
      chk("cmp_receive_led", ReceiveLED, m_led);
      if (WriteStrobe === 1'b1) begin
        s_data.push_back(WriteData);
        s_cyc.push_back(cyc);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_valid = 1'b0;
    end
  endtask

  task automatic post();
    @(posedge clk);
    #1;
  endtask

  task automatic send_sync();
    send(8'hFA); send(8'hB0); send(8'hFA); send(8'hB1);
  endtask

  initial begin : stim
    int s0;
    logic [7:0] noise[8];

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_rx_ready", rx_ready, 0);
    chk("reset_com_active", ComActive, 0);
    chk("reset_write_data", WriteData, 0);
    reset = 1'b0;
    post();
    chk("ready_after_reset", rx_ready, 1);

    // Basic single write
    s0 = s_data.size();
    send_sync(); send(8'h81);
    send(8'h12); send(8'h34); send(8'h56); send(8'h78);
    post();
    chk("w1_strobe", WriteStrobe, 1);
    chk("w1_data", WriteData, 32'h1234_5678);
    chk("w1_model_data", m_wd, 32'h1234_5678);
    chk("w1_led", ReceiveLED, 1);
    chk("w1_command", Command, 8'h81);
    chk("w1_active", ComActive, 1);
    idle(1); post();
    chk("w1_strobe_single", WriteStrobe, 0);
    chk("w1_data_hold", WriteData, 32'h1234_5678);
    idle(20);
    chk("w1_timeout_active", ComActive, 0);
    chk("w1_strobe_count", s_data.size() - s0, 1);

    // Back-to-back words
    s0 = s_data.size();
    send_sync(); send(8'h81);
    for (int i = 0; i < 8; i++) send(8'(i));
    idle(20);
    chk("b2b_strobe_count", s_data.size() - s0, 2);
    if (s_data.size() >= s0 + 2) begin
      chk("b2b_word0", s_data[s0], 32'h0001_0203);
      chk("b2b_word1", s_data[s0+1], 32'h0405_0607);
      chk("b2b_spacing", s_cyc[s0+1] - s_cyc[s0], 4);
    end

    // Non-write command closes the session
    s0 = s_data.size();
    send_sync(); post();
    chk("cmd55_open", ComActive, 1);
    send(8'h55); post();
    chk("cmd55_command", Command, 8'h55);
    chk("cmd55_closed", ComActive, 0);
    idle(3);
    chk("cmd55_no_strobe", s_data.size() - s0, 0);

    // Timeout discards a partial word
    s0 = s_data.size();
    send_sync(); send(8'h81); send(8'hAA); send(8'hBB); post();
    for (int n = 1; n <= TO; n++) begin
      idle(1); post();
      chk("to_active_edge", ComActive, (n < TO) ? 1 : 0);
    end
    chk("to_no_strobe", s_data.size() - s0, 0);
    send_sync(); send(8'h81);
    send(8'hC0); send(8'hFF); send(8'hEE); send(8'h01); post();
    chk("to_restart_strobe", WriteStrobe, 1);
    chk("to_restart_data", WriteData, 32'hC0FF_EE01);
    idle(20);

    // Byte arriving on the expiry cycle wins
    send_sync(); send(8'h81);
    idle(TO - 1);
    send(8'hD1); post();
    chk("race_active", ComActive, 1);
    send(8'hD2); send(8'hD3); send(8'hD4); post();
    chk("race_strobe", WriteStrobe, 1);
    chk("race_data", WriteData, 32'hD1D2_D3D4);
    idle(20);

    // Sync pattern inside data is plain data
    send_sync(); send(8'h81);
    send_sync(); post();
    chk("syncdata_strobe", WriteStrobe, 1);
    chk("syncdata_data", WriteData, SYNC);
    chk("syncdata_active", ComActive, 1);
    send(8'h81); send(8'h02); send(8'h03); send(8'h04); post();
    chk("syncdata_next_data", WriteData, 32'h8102_0304);
    idle(20);

    // Reset mid-word
    send_sync(); send(8'h81); send(8'h11); send(8'h22); send(8'h33); post();
    @(negedge clk);
    reset = 1'b1;
    rx_valid = 1'b0;
    post();
    chk("rst_rx_ready", rx_ready, 0);
    chk("rst_write_data", WriteData, 0);
    chk("rst_strobe", WriteStrobe, 0);
    chk("rst_active", ComActive, 0);
    chk("rst_command", Command, 0);
    chk("rst_led", ReceiveLED, 0);
    @(negedge clk);
    reset = 1'b0;
    s0 = s_data.size();
    send_sync(); send(8'h81);
    send(8'hA1); send(8'hA2); send(8'hA3); send(8'hA4); post();
    chk("rst_after_data", WriteData, 32'hA1A2_A3A4);
    chk("rst_after_model", m_wd, 32'hA1A2_A3A4);
    chk("rst_after_led", ReceiveLED, 1);
    idle(20);
    chk("rst_after_count", s_data.size() - s0, 1);

    // Noise before the sync pattern
    noise = '{8'h00, 8'hFA, 8'hB0, 8'hFA, 8'hFA, 8'hB0, 8'hFA, 8'hB1};
    for (int i = 0; i < 8; i++) begin
      send(noise[i]); post();
      chk("noise_active", ComActive, (i == 7) ? 1 : 0);
    end
    send(8'h81); post();
    chk("noise_command", Command, 8'h81);
    idle(20);
    chk("noise_closed", ComActive, 0);

    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
